mlx5_command_str_lut: RTL and testbench

//  Parametrised, pipelined successor of the mlx5 command-to-string lookup: maps a command opcode to a
//  PTR_W-bit string-descriptor pointer via a runtime-programmable CAM table instead of a fixed switch.

---
 rtl/mlx5_command_str_lut.sv | 123 ++++++++++++
 tb/tb_mlx5_command_str_lut.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mlx5_command_str_lut.sv
// Opcode-to-string-pointer lookup: a programmable CAM table behind a one-stage input register,
// with results queued in a first-word-fall-through FIFO and a saturating miss counter.
module mlx5_command_str_lut #(
  parameter int               CMD_W       = 32,
  parameter int               PTR_W       = 64,
  parameter int               ENTRIES     = 16,
  parameter int               FIFO_DEPTH  = 4,
  parameter logic [PTR_W-1:0] DEFAULT_PTR = '0,
  localparam int              IDX_W       = $clog2(ENTRIES)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  output logic             busy,
  input  logic [CMD_W-1:0] command,
  output logic             done,
  input  logic             stall,
  output logic [PTR_W-1:0] returndata,
  output logic             hit,
  input  logic             cfg_we,
  input  logic [IDX_W-1:0] cfg_idx,
  input  logic             cfg_valid,
  input  logic [CMD_W-1:0] cfg_opcode,
  input  logic [PTR_W-1:0] cfg_ptr,
  output logic [31:0]      miss_count
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  // Handshakes: a command moves on start && !busy; a result moves on done && !stall.
  logic [ENTRIES-1:0] ent_valid_q;
  logic [CMD_W-1:0]   ent_op_q  [ENTRIES];
  logic [PTR_W-1:0]   ent_ptr_q [ENTRIES];

  logic             s1_valid_q, s1_valid_d;
  logic [CMD_W-1:0] s1_op_q, s1_op_d;

  logic [PTR_W-1:0]      fifo_ptr_q [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] fifo_hit_q;
  logic [AW-1:0]         rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0]         count_q, count_d;
  logic [31:0]           miss_count_q, miss_count_d;

  logic             accept, push, pop;
  logic             match_hit;
  logic [PTR_W-1:0] match_ptr;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Busy depends only on registered occupancy (plus reset), so stall never reaches busy.
  assign busy   = reset | ((int'(count_q) + int'(s1_valid_q)) >= FIFO_DEPTH);
  assign accept = start && !busy;
  assign done   = (count_q != '0);
  assign push   = s1_valid_q;
  assign pop    = done && !stall;

  always_ff @(posedge clock) begin
    if (reset) begin
      ent_valid_q <= '0;
    end else if (cfg_we && (int'(cfg_idx) < ENTRIES)) begin
      ent_valid_q[cfg_idx] <= cfg_valid;
      ent_op_q[cfg_idx]    <= cfg_opcode;
      ent_ptr_q[cfg_idx]   <= cfg_ptr;
    end
  end

  // Scan from the top so the lowest matching index is the last to assign.
  always_comb begin
    match_hit = 1'b0;
    match_ptr = DEFAULT_PTR;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (ent_valid_q[i] && (ent_op_q[i] == s1_op_q)) begin
        match_hit = 1'b1;
        match_ptr = ent_ptr_q[i];
      end
    end
  end

  always_comb begin
    s1_valid_d   = accept;
    s1_op_d      = accept ? command : s1_op_q;
    wr_d         = push ? ptr_inc(wr_q) : wr_q;
    rd_d         = pop ? ptr_inc(rd_q) : rd_q;
    count_d      = count_q + CW'(push) - CW'(pop);
    miss_count_d = miss_count_q;
    if (push && !match_hit && (miss_count_q != 32'hFFFF_FFFF)) begin
      miss_count_d = miss_count_q + 32'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      s1_valid_q   <= 1'b0;
      rd_q         <= '0;
      wr_q         <= '0;
      count_q      <= '0;
      miss_count_q <= '0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      rd_q         <= rd_d;
      wr_q         <= wr_d;
      count_q      <= count_d;
      miss_count_q <= miss_count_d;
    end
  end

  // Datapath storage needs no reset; occupancy alone decides what is visible.
  always_ff @(posedge clock) begin
    s1_op_q <= s1_op_d;
    if (push) begin
      fifo_ptr_q[wr_q] <= match_ptr;
      fifo_hit_q[wr_q] <= match_hit;
    end
  end

  assign returndata = done ? fifo_ptr_q[rd_q] : '0;
  assign hit        = done & fifo_hit_q[rd_q];
  assign miss_count = miss_count_q;

endmodule

// File: tb/tb_mlx5_command_str_lut.sv
// Bench for mlx5_command_str_lut: directed scenarios plus randomized traffic, table writes and
// stall, checked through an expected-result queue filled by a table-lookup reference model.
module tb_mlx5_command_str_lut;

  localparam int               CMD_W       = 32;
  localparam int               PTR_W       = 64;
  localparam int               ENTRIES     = 16;
  localparam int               FIFO_DEPTH  = 4;
  localparam logic [PTR_W-1:0] DEFAULT_PTR = 64'h0000_0000_DEAD_BEEF;
  localparam logic [PTR_W-1:0] PTR_A       = 64'hAAAA_0000_0000_0001;
  localparam logic [PTR_W-1:0] PTR_B       = 64'hBBBB_0000_0000_0002;
  localparam logic [PTR_W-1:0] PTR_C       = 64'hCCCC_0000_0000_0003;
  localparam logic [PTR_W-1:0] PTR_NEW     = 64'h1234_5678_9ABC_DEF0;

  logic             clock, reset, start, busy, done, stall, hit;
  logic [CMD_W-1:0] command, cfg_opcode;
  logic [PTR_W-1:0] returndata, cfg_ptr;
  logic             cfg_we, cfg_valid;
  logic [3:0]       cfg_idx;
  logic [31:0]      miss_count;

  mlx5_command_str_lut #(
    .CMD_W(CMD_W), .PTR_W(PTR_W), .ENTRIES(ENTRIES),
    .FIFO_DEPTH(FIFO_DEPTH), .DEFAULT_PTR(DEFAULT_PTR)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .busy(busy), .command(command),
    .done(done), .stall(stall), .returndata(returndata), .hit(hit),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_valid(cfg_valid),
    .cfg_opcode(cfg_opcode), .cfg_ptr(cfg_ptr), .miss_count(miss_count)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model and scoreboard state ----------------
  logic [PTR_W:0]   exp_q[$];
  bit               m_valid [ENTRIES];
  logic [CMD_W-1:0] m_op    [ENTRIES];
  logic [PTR_W-1:0] m_ptr   [ENTRIES];
  logic [31:0]      m_miss;
  bit               pend_valid;
  logic [CMD_W-1:0] pend_op;
  bit               force_req, forced;
  logic [PTR_W-1:0] last_ptr;
  logic             last_hit;
  int               checks, errors;
  int               stall_mode;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [PTR_W:0] ref_lookup(input logic [CMD_W-1:0] op);
    for (int i = 0; i < ENTRIES; i++) begin
      if (m_valid[i] && m_op[i] == op) return {1'b1, m_ptr[i]};
    end
    return {1'b0, DEFAULT_PTR};
  endfunction

  // Model acts just before each rising edge: a command accepted last edge is looked up now
  // against the table as it stands before this edge's write.
  initial begin
    pend_valid = 0; pend_op = '0; m_miss = '0; forced = 0;
    for (int i = 0; i < ENTRIES; i++) begin
      m_valid[i] = 0; m_op[i] = '0; m_ptr[i] = '0;
    end
    forever begin
      @(negedge clock); #4;
      if (reset) begin
        pend_valid = 0;
        m_miss = '0;
        exp_q.delete();
        for (int i = 0; i < ENTRIES; i++) m_valid[i] = 0;
      end else begin
        if (pend_valid) begin
          logic [PTR_W:0] r;
          r = ref_lookup(pend_op);
          exp_q.push_back(r);
          if (!r[PTR_W] && m_miss != 32'hFFFF_FFFF) m_miss = m_miss + 1;
        end
        pend_valid = start && !busy;
        pend_op    = command;
        if (cfg_we) begin
          m_valid[cfg_idx] = cfg_valid;
          m_op[cfg_idx]    = cfg_opcode;
          m_ptr[cfg_idx]   = cfg_ptr;
        end
      end
      if (force_req && !forced) begin
        force dut.miss_count_q = 32'hFFFF_FFFD;
        m_miss = 32'hFFFF_FFFD;
        forced = 1;
      end else if (!force_req && forced) begin
        release dut.miss_count_q;
        forced = 0;
      end
    end
  end

  // Monitor: pops one expected result per accepted output beat.
  initial begin
    last_ptr = '0; last_hit = 1'b0;
    forever begin
      @(negedge clock); #3;
      if (!reset) begin
        chk("miss_count", miss_count, m_miss);
        if (done && !stall) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_result", {done, returndata}, {1'b0, returndata});
          end else begin
            logic [PTR_W:0] e;
            e = exp_q.pop_front();
            chk("returndata", returndata, e[PTR_W-1:0]);
            chk("hit", hit, e[PTR_W]);
            last_ptr = returndata;
            last_hit = hit;
          end
        end
      end
    end
  end

  always begin
    @(negedge clock); #1;
    case (stall_mode)
      0:       stall = 1'b0;
      1:       stall = 1'b1;
      default: stall = ($urandom_range(0, 3) == 0);
    endcase
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [CMD_W-1:0] op);
    int  n;
    bit  acc;
    n = 0; acc = 0;
    start = 1'b1; command = op;
    do begin
      #4; acc = !busy;
      @(negedge clock);
      cfg_we = 1'b0;
      n++;
    end while (!acc && n < 300);
    start = 1'b0;
    chk("send_accept", acc, 1'b1);
  endtask

  task automatic cfg_write(input int idx, input logic v, input logic [CMD_W-1:0] op,
                           input logic [PTR_W-1:0] p);
    cfg_we = 1'b1; cfg_idx = 4'(idx); cfg_valid = v; cfg_opcode = op; cfg_ptr = p;
    @(negedge clock);
    cfg_we = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || done || pend_valid) && n < 500) begin
      @(negedge clock);
      n++;
    end
    chk("drain_timeout", n < 500, 1'b1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [CMD_W-1:0] pool [8];
    int acc;
    bit acc_now;
    checks = 0; errors = 0; stall_mode = 0; force_req = 0;
    reset = 1'b1; start = 1'b0; command = '0; stall = 1'b0;
    cfg_we = 1'b0; cfg_idx = '0; cfg_valid = 1'b0; cfg_opcode = '0; cfg_ptr = '0;

    @(negedge clock);
    chk("reset_done", done, 1'b0);
    chk("reset_returndata", returndata, '0);
    chk("reset_hit", hit, 1'b0);
    chk("reset_busy", busy, 1'b1);
    chk("reset_miss", miss_count, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);

    // 1: single hit, latency 2
    cfg_write(0, 1'b1, 32'h100, PTR_A);
    send(32'h100);
    chk("t1_done_latency1", done, 1'b0);
    @(negedge clock);
    chk("t1_done_latency2", done, 1'b1);
    chk("t1_ptr", returndata, PTR_A);
    chk("t1_hit", hit, 1'b1);
    wait_drain();

    // 2: miss
    send(32'h999);
    wait_drain();
    chk("t2_ptr", last_ptr, DEFAULT_PTR);
    chk("t2_hit", last_hit, 1'b0);
    chk("t2_miss", miss_count, 32'd1);

    // 3: lowest index wins, then fall through after invalidation
    cfg_write(2, 1'b1, 32'h200, PTR_B);
    cfg_write(5, 1'b1, 32'h200, PTR_C);
    send(32'h200);
    wait_drain();
    chk("t3_lowest", last_ptr, PTR_B);
    cfg_write(2, 1'b0, 32'h200, PTR_B);
    send(32'h200);
    wait_drain();
    chk("t3_next", last_ptr, PTR_C);

    // 4: backpressure fills FIFO + s1, then releases in order
    for (int i = 0; i < 8; i++) cfg_write(8 + i, 1'b1, 32'h300 + 32'(i), 64'h3000 + 64'(i));
    stall_mode = 1;
    @(negedge clock);
    acc = 0; start = 1'b1; command = 32'h300;
    for (int c = 0; c < 12; c++) begin
      #4; acc_now = !busy;
      @(negedge clock);
      if (acc_now) begin
        acc++;
        command = 32'h300 + 32'(acc);
      end
    end
    start = 1'b0;
    chk("t4_busy", busy, 1'b1);
    chk("t4_accepted", acc, FIFO_DEPTH);
    chk("t4_head_held", returndata, 64'h3000);
    stall_mode = 0;
    for (int i = acc; i < 8; i++) send(32'h300 + 32'(i));
    wait_drain();
    chk("t4_last", last_ptr, 64'h3007);

    // 5: table write on the compare edge does not affect that compare
    send(32'h100);
    cfg_write(0, 1'b1, 32'h100, PTR_NEW);
    wait_drain();
    chk("t5_old", last_ptr, PTR_A);
    send(32'h100);
    wait_drain();
    chk("t5_new", last_ptr, PTR_NEW);

    // 6: reset with buffered results, then saturation
    stall_mode = 1;
    @(negedge clock);
    send(32'h999); send(32'h999); send(32'h100);
    @(negedge clock);
    chk("t6_buffered", done, 1'b1);
    reset = 1'b1;
    @(negedge clock);
    chk("t6_reset_done", done, 1'b0);
    chk("t6_reset_miss", miss_count, 32'd0);
    chk("t6_reset_busy", busy, 1'b1);
    reset = 1'b0;
    stall_mode = 0;
    @(negedge clock);
    force_req = 1;
    repeat (2) @(negedge clock);
    chk("t6_forced", miss_count, 32'hFFFF_FFFD);
    force_req = 0;
    repeat (2) @(negedge clock);
    send(32'h999); send(32'h999); send(32'h999);
    wait_drain();
    chk("t6_saturate", miss_count, 32'hFFFF_FFFF);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);

    // random traffic with table writes and stall
    for (int i = 0; i < 8; i++) pool[i] = $urandom_range(0, 15) << 4;
    for (int i = 0; i < 8; i++) cfg_write(i, 1'b1, pool[i], {$urandom, $urandom});
    stall_mode = 2;
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 4) == 0) begin
        cfg_we = 1'b1; cfg_idx = 4'($urandom_range(0, 15));
        cfg_valid = ($urandom_range(0, 3) != 0);
        cfg_opcode = pool[$urandom_range(0, 7)];
        cfg_ptr = {$urandom, $urandom};
      end
      if ($urandom_range(0, 3) == 0) send($urandom);
      else send(pool[$urandom_range(0, 7)]);
      if ($urandom_range(0, 3) == 0) @(negedge clock);
    end
    stall_mode = 0;
    wait_drain();
    chk("final_queue_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
